// File: rtl/ex_mem_pkg.sv
// EX/MEM stage shared types: captured entry layout, stage FSM states and the
// branch offset shift.
package ex_mem_pkg;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_REG_AW = 5;
    localparam int BR_SHIFT     = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ex_mem_state_t;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] alu_result;
        logic [ENTRY_DATA_W-1:0] store_data;
        logic [ENTRY_REG_AW-1:0] rd_addr;
        logic                    zero;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
    } ex_mem_entry_t;

    function automatic ex_mem_entry_t entry_clear();
        return '0;
    endfunction

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Branch resolution for beq/bne: taken decision and word-aligned target.
module branch_resolve
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              zero,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] imm_sext,
    output logic              taken,
    output logic [DATA_W-1:0] target
);

    // bne inverts the sense of Zero; target wraps modulo 2^DATA_W
    always_comb begin
        taken  = branch & (branch_ne ? ~zero : zero);
        target = pc_plus4 + (imm_sext << BR_SHIFT);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer and branch resolution.
// Optional forwarding outputs are built when EX_MEM_FWD_EN is defined.
//
// state | meaning
// EMPTY | no entry held, outputs invalid
// ONE   | main entry valid on outputs, skid free
// TWO   | main entry on outputs, skid holds the next entry, not ready
//
// Entry fields use the package widths; DATA_W/REG_AW must stay at 32/5.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = ENTRY_DATA_W,
    parameter int REG_AW = ENTRY_REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_zero,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_branch,
    input  logic              i_branch_ne,
    input  logic [DATA_W-1:0] i_pc_plus4,
    input  logic [DATA_W-1:0] i_imm_sext,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_store_data,
    output logic              o_zero,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [REG_AW-1:0] o_rd_addr,
`ifdef EX_MEM_FWD_EN
    output logic              o_fwd_valid,
    output logic [REG_AW-1:0] o_fwd_rd,
    output logic [DATA_W-1:0] o_fwd_data,
`endif
    output logic              o_br_taken,
    output logic [DATA_W-1:0] o_br_target
);

    ex_mem_state_t state_q, state_d;
    ex_mem_entry_t main_q, main_d;
    ex_mem_entry_t skid_q, skid_d;
    ex_mem_entry_t new_entry;
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_target_q, br_target_d;
    logic              accept;
    logic              taken;
    logic [DATA_W-1:0] target;

    branch_resolve #(.DATA_W(DATA_W)) u_branch_resolve (
        .zero      (i_zero),
        .branch    (i_branch),
        .branch_ne (i_branch_ne),
        .pc_plus4  (i_pc_plus4),
        .imm_sext  (i_imm_sext),
        .taken     (taken),
        .target    (target)
    );

    // Ready depends only on registered state, never on i_ready
    assign o_ready = (state_q != TWO);
    assign accept  = i_valid & o_ready & ~i_flush;

    // Capture the incoming instruction; writes to $zero are suppressed here
    always_comb begin
        new_entry            = entry_clear();
        new_entry.alu_result = i_alu_result;
        new_entry.store_data = i_store_data;
        new_entry.rd_addr    = i_rd_addr;
        new_entry.zero       = i_zero;
        new_entry.reg_write  = i_reg_write & (i_rd_addr != '0);
        new_entry.mem_read   = i_mem_read;
        new_entry.mem_write  = i_mem_write;
    end

    // Next-state and buffer steering; flush overrides accept and i_ready
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        br_taken_d  = accept & taken;
        br_target_d = accept ? target : br_target_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = new_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && i_ready) begin
                        main_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = TWO;
                    end else if (i_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (i_ready) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, entries and branch pulse registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= EMPTY;
            main_q      <= entry_clear();
            skid_q      <= entry_clear();
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign o_valid      = (state_q != EMPTY);
    assign o_alu_result = main_q.alu_result;
    assign o_store_data = main_q.store_data;
    assign o_zero       = main_q.zero;
    assign o_reg_write  = main_q.reg_write;
    assign o_mem_read   = main_q.mem_read;
    assign o_mem_write  = main_q.mem_write;
    assign o_rd_addr    = main_q.rd_addr;
    assign o_br_taken   = br_taken_q;
    assign o_br_target  = br_target_q;

`ifdef EX_MEM_FWD_EN
    assign o_fwd_valid = o_valid & o_reg_write & ~o_mem_read;
    assign o_fwd_rd    = main_q.rd_addr;
    assign o_fwd_data  = main_q.alu_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, o_ready, i_zero, i_reg_write, i_mem_read, i_mem_write;
    logic        i_branch, i_branch_ne, i_flush, o_valid, i_ready;
    logic [31:0] i_alu_result, i_store_data, i_pc_plus4, i_imm_sext;
    logic [4:0]  i_rd_addr, o_rd_addr;
    logic [31:0] o_alu_result, o_store_data, o_br_target;
    logic        o_zero, o_reg_write, o_mem_read, o_mem_write, o_br_taken;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        z, rw, mr, mw;
    } exp_t;

    exp_t        fifo[$];
    bit          exp_br = 0;
    logic [31:0] exp_tgt = '0;

    always #5 i_clk = ~i_clk;

    ex_mem_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_result(i_alu_result), .i_zero(i_zero), .i_store_data(i_store_data),
        .i_rd_addr(i_rd_addr), .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_branch(i_branch), .i_branch_ne(i_branch_ne),
        .i_pc_plus4(i_pc_plus4), .i_imm_sext(i_imm_sext), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_result(o_alu_result),
        .o_store_data(o_store_data), .o_zero(o_zero), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_rd_addr(o_rd_addr),
        .o_br_taken(o_br_taken), .o_br_target(o_br_target)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_model();
        check_val("valid", 64'(o_valid), 64'(fifo.size() > 0));
        check_val("ready", 64'(o_ready), 64'(fifo.size() < 2));
        check_val("br_taken", 64'(o_br_taken), 64'(exp_br));
        if (exp_br) check_val("br_target", 64'(o_br_target), 64'(exp_tgt));
        if (fifo.size() > 0 && o_valid === 1'b1) begin
            check_val("alu_result", 64'(o_alu_result), 64'(fifo[0].alu));
            check_val("store_data", 64'(o_store_data), 64'(fifo[0].sd));
            check_val("rd_addr", 64'(o_rd_addr), 64'(fifo[0].rd));
            check_val("zero", 64'(o_zero), 64'(fifo[0].z));
            check_val("reg_write", 64'(o_reg_write), 64'(fifo[0].rw));
            check_val("mem_read", 64'(o_mem_read), 64'(fifo[0].mr));
            check_val("mem_write", 64'(o_mem_write), 64'(fifo[0].mw));
        end
    endtask

    // Behavioural view: a 2-deep FIFO; upstream may push while it holds
    // fewer than two entries, MEM pops the head whenever i_ready is high.
    task automatic cycle();
        exp_t e;
        bit   acc;
        int   n;
        n = fifo.size();
        if (!i_rst_n) begin
            fifo.delete();
            exp_br  = 0;
            exp_tgt = '0;
        end else if (i_flush) begin
            fifo.delete();
            exp_br = 0;
        end else begin
            acc = i_valid && (n < 2);
            if (n > 0 && i_ready) void'(fifo.pop_front());
            if (acc) begin
                e.alu = i_alu_result; e.sd = i_store_data; e.rd = i_rd_addr;
                e.z = i_zero; e.rw = i_reg_write && (i_rd_addr != 0);
                e.mr = i_mem_read; e.mw = i_mem_write;
                fifo.push_back(e);
            end
            exp_br = acc && i_branch && (i_branch_ne ? !i_zero : i_zero);
            if (exp_br) exp_tgt = i_pc_plus4 + i_imm_sext * 32'd4;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        compare_model();
    endtask

    task automatic clear_in();
        i_valid = 0; i_alu_result = '0; i_zero = 0; i_store_data = '0; i_rd_addr = '0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0; i_branch = 0; i_branch_ne = 0;
        i_pc_plus4 = '0; i_imm_sext = '0; i_flush = 0;
    endtask

    task automatic push(input logic [31:0] alu, input logic [4:0] rd);
        i_valid = 1; i_alu_result = alu; i_rd_addr = rd; i_reg_write = 1;
        i_store_data = alu ^ 32'hA5A5_0000;
    endtask

    initial begin
        clear_in();
        i_rst_n = 0; i_ready = 1;
        cycle(); cycle();
        check_val("rst_valid", 64'(o_valid), 64'd0);
        check_val("rst_ready", 64'(o_ready), 64'd1);
        check_val("rst_br_taken", 64'(o_br_taken), 64'd0);
        check_val("rst_br_target", 64'(o_br_target), 64'd0);

        // Single accept, latency 1
        i_rst_n = 1;
        push(32'h7, 5'd3);
        cycle();
        check_val("t1_alu", 64'(o_alu_result), 64'd7);
        check_val("t1_rd", 64'(o_rd_addr), 64'd3);
        check_val("t1_rw", 64'(o_reg_write), 64'd1);
        clear_in(); cycle();

        // Back-pressure: A on outputs, B in skid, C held upstream
        i_ready = 0;
        push(32'd1, 5'd1); cycle();
        check_val("bp_a", 64'(o_alu_result), 64'd1);
        push(32'd2, 5'd2); cycle();
        check_val("bp_ready_low", 64'(o_ready), 64'd0);
        push(32'd3, 5'd3); cycle();
        check_val("bp_hold_a", 64'(o_alu_result), 64'd1);
        i_ready = 1; cycle();
        check_val("bp_b", 64'(o_alu_result), 64'd2);
        cycle();
        check_val("bp_c", 64'(o_alu_result), 64'd3);
        clear_in(); cycle();
        check_val("bp_drained", 64'(o_valid), 64'd0);

        // beq taken, then bne with same operands not taken
        i_valid = 1; i_branch = 1; i_zero = 1; i_pc_plus4 = 32'h100; i_imm_sext = 32'hFFFF_FFFC;
        cycle();
        check_val("beq_pulse", 64'(o_br_taken), 64'd1);
        check_val("beq_target", 64'(o_br_target), 64'h0F0);
        i_valid = 0; cycle();
        check_val("beq_one_cycle", 64'(o_br_taken), 64'd0);
        i_valid = 1; i_branch_ne = 1; cycle();
        check_val("bne_no_pulse", 64'(o_br_taken), 64'd0);
        clear_in(); cycle();

        // $zero destination
        push(32'h55, 5'd0); cycle();
        check_val("rd0_rw", 64'(o_reg_write), 64'd0);
        clear_in(); cycle();

        // Flush in TWO with a taken branch presented alongside
        i_ready = 0;
        push(32'h11, 5'd4); cycle();
        push(32'h12, 5'd5); cycle();
        i_flush = 1; i_branch = 1; i_zero = 1; cycle();
        check_val("flush_valid", 64'(o_valid), 64'd0);
        check_val("flush_ready", 64'(o_ready), 64'd1);
        check_val("flush_br", 64'(o_br_taken), 64'd0);
        clear_in(); cycle();

        // Reset while in TWO with back-pressure, then normal accept
        push(32'h21, 5'd6); cycle();
        push(32'h22, 5'd7); cycle();
        i_rst_n = 0; cycle();
        check_val("rst2_valid", 64'(o_valid), 64'd0);
        check_val("rst2_ready", 64'(o_ready), 64'd1);
        check_val("rst2_target", 64'(o_br_target), 64'd0);
        i_rst_n = 1; i_ready = 1;
        push(32'h33, 5'd8); cycle();
        check_val("rst2_after", 64'(o_alu_result), 64'h33);
        clear_in(); cycle();

        // Randomized traffic against the FIFO model
        for (int k = 0; k < 3000; k++) begin
            i_rst_n      = ($urandom_range(0, 199) != 0);
            i_flush      = ($urandom_range(0, 24) == 0);
            i_valid      = ($urandom_range(0, 3) != 0);
            i_ready      = ($urandom_range(0, 2) != 0);
            i_alu_result = $urandom;
            i_store_data = $urandom;
            i_rd_addr    = 5'($urandom_range(0, 31));
            i_zero       = 1'($urandom_range(0, 1));
            i_reg_write  = 1'($urandom_range(0, 1));
            i_mem_read   = 1'($urandom_range(0, 1));
            i_mem_write  = 1'($urandom_range(0, 1));
            i_branch     = ($urandom_range(0, 2) == 0);
            i_branch_ne  = 1'($urandom_range(0, 1));
            i_pc_plus4   = $urandom;
            i_imm_sext   = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
